poly_op_sequencer: RTL and testbench
====================================

# poly_op_sequencer

Command-level controller that sequences the polynomial address unit for one 64-beat polynomial operation (forward NTT, inverse NTT, pointwise MULT, ADD, SUB). It accepts a command over a valid/ready handshake and issues the address unit's init pulse and per-beat enable. It inserts pipeline bubbles between NTT rounds, honours datapath stall, cross-checks the unit's `ntt_round_done`/`done` against its own beat count, and reports completion after the butterfly pipeline drains.

## Interface
Parameters:
- `ROUND_GAP`, 2: enable-low bubble cycles between NTT rounds (0..15).
- `DRAIN`, 4: cycles from final beat to `op_done` (1..15), covering datapath latency.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_mode`  in  3  0 FWD_NTT, 1 INV_NTT, 2 MULT, 3 ADD, 4 SUB; 5..7 illegal.
- `cmd_map`  in  2  resolver mapping: 0 DECODE, 1 ENCODE, 2/3 STANDARD.
- `stall`  in  1  datapath back-pressure; forces `au_en` low that cycle.
- `au_mode`  out  3  registered copy of accepted `cmd_mode`.
- `au_map`  out  2  registered copy of accepted `cmd_map`.
- `au_rst`  out  1  one-cycle init pulse to address unit.
- `au_en`  out  1  beat enable to address unit.
- `au_round_done`  in  1  address unit round-complete pulse.
- `au_done`  in  1  address unit operation-complete pulse.
- `busy`  out  1  high in any state except IDLE.
- `op_done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle error pulse (illegal mode or handshake mismatch).

## Operation
- States: IDLE, INIT, RUN, GAP, DRAIN.
- IDLE: `cmd_ready`=1. Handshake on `cmd_valid && cmd_ready`. Legal mode: latch `au_mode`/`au_map`, clear `beat`/`round`, go INIT. Illegal mode: pulse `err` next cycle, stay IDLE, latches unchanged.
- INIT (1 cycle): `au_rst`=1, `au_en`=0; go RUN.
- RUN: `au_en = !stall`. `beat` (6-bit) increments on each enabled cycle. Round length L = 64, except INV_NTT round 0, where L = 63 because the unit's index starts at 1.
- On the enabled cycle with `beat` = L−1:
  - Elementwise modes: go DRAIN.
  - NTT, `round` < 3: `round`++, `beat`←0, go GAP (or directly RUN if `ROUND_GAP`=0).
  - NTT, `round` = 3: go DRAIN.
- GAP: `au_en`=0 for exactly `ROUND_GAP` cycles, counted regardless of `stall`; then RUN.
- DRAIN: `au_en`=0; counter runs `DRAIN` cycles; last cycle pulses `op_done`; go IDLE.
- Consistency checks, sampled the cycle after each round's final beat:
  - NTT non-final round: `au_round_done` must be 1 and `au_done` 0.
  - NTT final round: both must be 1.
  - Elementwise: `au_done` must be 1.
  - `au_round_done` or `au_done` seen at any other time is also an error.
  - On mismatch: pulse `err`, abort to IDLE immediately, suppress `op_done`.
- New command accepted only in IDLE; `cmd_valid` ignored otherwise.

## Timing
- Reset values: state IDLE, `cmd_ready`=1, `busy`=0, `au_rst`=0, `au_en`=0, `op_done`=0, `err`=0, `au_mode`=0, `au_map`=2 (STANDARD), counters 0.
- `rst` mid-operation: returns to IDLE next cycle; no `op_done`, no `err`; address unit is left un-enabled.
- All outputs are registered except `au_en`, which is state-decoded AND `!stall` (combinational from `stall`, one gate).
- Accept at edge T: INIT at T+1, first possible enabled beat at T+2.
- No-stall latency from accept edge to `op_done` high:
  - Elementwise: 1 + 64 + `DRAIN`.
  - FWD_NTT: 1 + 256 + 3·`ROUND_GAP` + `DRAIN`.
  - INV_NTT: 1 + 255 + 3·`ROUND_GAP` + `DRAIN`.
- Earliest next accept: cycle after `op_done`. `busy` falls on the same edge as `op_done` clears.
- `stall` during GAP/DRAIN/INIT has no effect. `stall` held indefinitely in RUN freezes `beat` with no timeout.

## Test plan
- ADD, map=2, no stall, DRAIN=4: `au_rst` one cycle; `au_en` high exactly 64 consecutive cycles; `au_done` check passes; `op_done` 69 cycles after accept; `err`=0.
- FWD_NTT, ROUND_GAP=2: four 64-beat enable bursts separated by exactly 2 low cycles; `op_done` at 1+256+6+4=267; `err` never set.
- INV_NTT: first burst 63 beats, then 64/64/64; `au_done` coincides with final check; `op_done` at 266.
- MULT with `stall` asserted on beats 10–14 and 40: `au_en` low on exactly those 6 cycles; 64 total enabled beats; `op_done` delayed by 6 cycles.
- Illegal mode 6: `err` pulse one cycle after accept; no `au_rst`/`au_en`; `cmd_ready` stays 1. Separately, force `au_round_done`=0 at round-0 check of FWD_NTT: `err` pulses, return to IDLE, no `op_done`.
- `rst` asserted at beat 100 of FWD_NTT: next cycle IDLE, `au_en`=0, `busy`=0, no `op_done`; a following SUB command completes normally.

Source files
------------

// File: rtl/poly_op_sequencer.sv
// ---------------------------------------------------------------------------
// poly_op_sequencer
//
// Runs one 64-beat polynomial operation (forward/inverse NTT, pointwise
// MULT, ADD, SUB) by driving the polynomial address unit. It does the
// following:
//   - accepts a command over a valid/ready handshake;
//   - issues a one-cycle init pulse, then per-beat enables;
//   - inserts enable-low bubbles between NTT rounds;
//   - honours datapath stall;
//   - cross-checks the unit's round/operation completion pulses against its
//     own beat count;
//   - raises op_done once the butterfly pipeline has drained.
//
// Parameters
//   ROUND_GAP  enable-low bubble cycles between NTT rounds (0..15)
//   DRAIN      cycles from the final beat to op_done (1..15)
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   cmd_valid      command offered
//   cmd_ready      command can be accepted (IDLE only)
//   cmd_mode[2:0]  0 FWD_NTT, 1 INV_NTT, 2 MULT, 3 ADD, 4 SUB, 5..7 illegal
//   cmd_map[1:0]   resolver mapping: 0 DECODE, 1 ENCODE, 2/3 STANDARD
//   stall          datapath back-pressure, gates au_en
//   au_mode[2:0]   latched mode of the accepted command
//   au_map[1:0]    latched mapping of the accepted command
//   au_rst         one-cycle init pulse to the address unit
//   au_en          beat enable to the address unit
//   au_round_done  address unit round-complete pulse
//   au_done        address unit operation-complete pulse
//   busy           operation in progress
//   op_done        one-cycle completion pulse
//   err            one-cycle error pulse
// ---------------------------------------------------------------------------
module poly_op_sequencer #(
    parameter int ROUND_GAP = 2,
    parameter int DRAIN     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_mode,
    input  logic [1:0] cmd_map,
    input  logic       stall,
    output logic [2:0] au_mode,
    output logic [1:0] au_map,
    output logic       au_rst,
    output logic       au_en,
    input  logic       au_round_done,
    input  logic       au_done,
    output logic       busy,
    output logic       op_done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_RUN   = 3'd2,
        S_GAP   = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    localparam logic [2:0] MODE_FWD = 3'd0;
    localparam logic [2:0] MODE_INV = 3'd1;
    localparam logic [2:0] MODE_SUB = 3'd4;

    // Shared 4-bit counter serves both the round gap and the drain window.
    localparam logic [3:0] GAP_LAST   = (ROUND_GAP > 0) ? 4'(ROUND_GAP - 1) : 4'd0;
    localparam logic [3:0] DRAIN_LAST = (DRAIN > 0) ? 4'(DRAIN - 1) : 4'd0;
    localparam logic       GAP_EN     = (ROUND_GAP > 0);

    // What the pending consistency check expects from the address unit.
    localparam logic [1:0] CHK_ELEM  = 2'd0;
    localparam logic [1:0] CHK_MID   = 2'd1;
    localparam logic [1:0] CHK_FINAL = 2'd2;

    // Legal modes are the five encoded operations 0..4.
    function automatic logic mode_is_legal(input logic [2:0] mode);
        return (mode <= MODE_SUB);
    endfunction

    function automatic logic mode_is_ntt(input logic [2:0] mode);
        return (mode == MODE_FWD) || (mode == MODE_INV);
    endfunction

    // The inverse NTT's round 0 is one beat short, because the address
    // unit's index starts at 1 for that round.
    function automatic logic [5:0] last_beat(input logic [2:0] mode, input logic [1:0] round);
        logic [5:0] lb;
        if ((mode == MODE_INV) && (round == 2'd0)) begin
            lb = 6'd62;
        end else begin
            lb = 6'd63;
        end
        return lb;
    endfunction

    state_t     state_q,     state_d;
    logic [5:0] beat_q,      beat_d;
    logic [1:0] round_q,     round_d;
    logic [3:0] cnt_q,       cnt_d;
    logic       chk_pend_q,  chk_pend_d;
    logic [1:0] chk_kind_q,  chk_kind_d;
    logic [2:0] au_mode_q,   au_mode_d;
    logic [1:0] au_map_q,    au_map_d;
    logic       au_rst_q,    au_rst_d;
    logic       cmd_ready_q, cmd_ready_d;
    logic       busy_q,      busy_d;
    logic       op_done_q,   op_done_d;
    logic       err_q,       err_d;

    logic       chk_fail_s;
    logic       is_ntt_s;

    assign is_ntt_s = mode_is_ntt(au_mode_q);

    // Consistency check: compare the address unit's completion pulses with
    // what the beat count says should happen this cycle.
    always_comb begin
        chk_fail_s = 1'b0;
        if (chk_pend_q) begin
            case (chk_kind_q)
                CHK_ELEM:  chk_fail_s = !au_done;
                CHK_MID:   chk_fail_s = !(au_round_done && !au_done);
                CHK_FINAL: chk_fail_s = !(au_round_done && au_done);
                default:   chk_fail_s = 1'b1;
            endcase
        end else if (state_q != S_IDLE) begin
            // A completion pulse that arrives outside a check slot means the unit and
            // the sequencer have lost step.
            chk_fail_s = au_round_done || au_done;
        end else begin
            chk_fail_s = 1'b0;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        round_d    = round_q;
        cnt_d      = cnt_q;
        chk_pend_d = 1'b0;
        chk_kind_d = chk_kind_q;
        au_mode_d  = au_mode_q;
        au_map_d   = au_map_q;
        op_done_d  = 1'b0;
        err_d      = 1'b0;

        if (chk_fail_s) begin
            // A mismatch aborts at once; op_done is never produced.
            state_d = S_IDLE;
            beat_d  = 6'd0;
            round_d = 2'd0;
            cnt_d   = 4'd0;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        if (mode_is_legal(cmd_mode)) begin
                            au_mode_d = cmd_mode;
                            au_map_d  = cmd_map;
                            beat_d    = 6'd0;
                            round_d   = 2'd0;
                            cnt_d     = 4'd0;
                            state_d   = S_INIT;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_INIT: begin
                    state_d = S_RUN;
                end
                S_RUN: begin
                    if (!stall) begin
                        if (beat_q == last_beat(au_mode_q, round_q)) begin
                            // Final beat of a round: the unit's pulse is checked next cycle.
                            chk_pend_d = 1'b1;
                            beat_d     = 6'd0;
                            cnt_d      = 4'd0;
                            if (!is_ntt_s) begin
                                chk_kind_d = CHK_ELEM;
                                state_d    = S_DRAIN;
                            end else if (round_q != 2'd3) begin
                                chk_kind_d = CHK_MID;
                                round_d    = round_q + 2'd1;
                                state_d    = GAP_EN ? S_GAP : S_RUN;
                            end else begin
                                chk_kind_d = CHK_FINAL;
                                state_d    = S_DRAIN;
                            end
                        end else begin
                            beat_d = beat_q + 6'd1;
                        end
                    end else begin
                        state_d = S_RUN;
                    end
                end
                S_GAP: begin
                    // Bubble length is fixed; stall does not stretch it.
                    if (cnt_q == GAP_LAST) begin
                        cnt_d   = 4'd0;
                        state_d = S_RUN;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                S_DRAIN: begin
                    if (cnt_q == DRAIN_LAST) begin
                        cnt_d     = 4'd0;
                        op_done_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Outputs are registered from the next state. The op_done cycle still
        // counts as the tail of the operation: busy is high and no command is
        // accepted until the following cycle.
        au_rst_d    = (state_d == S_INIT);
        cmd_ready_d = (state_d == S_IDLE) && !op_done_d;
        busy_d      = (state_d != S_IDLE) || op_done_d;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            beat_q      <= 6'd0;
            round_q     <= 2'd0;
            cnt_q       <= 4'd0;
            chk_pend_q  <= 1'b0;
            chk_kind_q  <= CHK_ELEM;
            au_mode_q   <= 3'd0;
            au_map_q    <= 2'd2;
            au_rst_q    <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            op_done_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            round_q     <= round_d;
            cnt_q       <= cnt_d;
            chk_pend_q  <= chk_pend_d;
            chk_kind_q  <= chk_kind_d;
            au_mode_q   <= au_mode_d;
            au_map_q    <= au_map_d;
            au_rst_q    <= au_rst_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            op_done_q   <= op_done_d;
            err_q       <= err_d;
        end
    end

    // The beat enable is the one combinational output: it has to react to
    // stall in the same cycle.
    assign au_en     = (state_q == S_RUN) && !stall;
    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign au_rst    = au_rst_q;
    assign au_mode   = au_mode_q;
    assign au_map    = au_map_q;
    assign op_done   = op_done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_poly_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_poly_op_sequencer
//
// Self-checking bench for poly_op_sequencer. A behavioural address-unit
// model answers each round's final beat with the expected completion pulses.
// The operation is tracked as a list of round lengths, a per-beat stall plan
// and fixed gap/drain windows. The bench checks outputs cycle by cycle, and
// also checks op_done latency against the closed-form formula.
// ---------------------------------------------------------------------------
module tb_poly_op_sequencer;

    localparam int RG = 2;
    localparam int DR = 4;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_mode;
    logic [1:0] cmd_map;
    logic       stall;
    logic [2:0] au_mode;
    logic [1:0] au_map;
    logic       au_rst;
    logic       au_en;
    logic       au_round_done;
    logic       au_done;
    logic       busy;
    logic       op_done;
    logic       err;

    int n_vec;
    int n_err;
    logic [2:0] last_mode;
    logic [1:0] last_map;

    poly_op_sequencer #(.ROUND_GAP(RG), .DRAIN(DR)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_mode      (cmd_mode),
        .cmd_map       (cmd_map),
        .stall         (stall),
        .au_mode       (au_mode),
        .au_map        (au_map),
        .au_rst        (au_rst),
        .au_en         (au_en),
        .au_round_done (au_round_done),
        .au_done       (au_done),
        .busy          (busy),
        .op_done       (op_done),
        .err           (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one cycle: drive inputs at the falling edge, then let outputs
    // (including the combinational au_en) settle before checking.
    task automatic step(input logic s, input logic rdv, input logic dnv,
                        input logic rstv, input bit junk);
        @(negedge clk);
        stall         = s;
        au_round_done = rdv;
        au_done       = dnv;
        rst           = rstv;
        if (junk) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_mode  = 3'($urandom_range(0, 7));
            cmd_map   = 2'($urandom_range(0, 3));
        end else begin
            cmd_valid = 1'b0;
        end
        #1;
    endtask

    task automatic offer(input logic [2:0] mode, input logic [1:0] map);
        @(negedge clk);
        cmd_valid     = 1'b1;
        cmd_mode      = mode;
        cmd_map       = map;
        stall         = 1'($urandom_range(0, 1));
        au_round_done = 1'b0;
        au_done       = 1'b0;
        rst           = 1'b0;
        #1;
        check("offer_ready", cmd_ready, 1);
        check("offer_busy", busy, 0);
    endtask

    // Idle window: no pulse of any kind may appear.
    task automatic watch(input int n);
        int pulses;
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0);
            if (op_done || err || au_en || au_rst) pulses++;
        end
        check("quiet_window", pulses, 0);
    endtask

    task automatic illegal(input logic [2:0] mode);
        offer(mode, 2'($urandom_range(0, 3)));
        step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0);
        check("ill_err", err, 1);
        check("ill_ready", cmd_ready, 1);
        check("ill_busy", busy, 0);
        check("ill_au_rst", au_rst, 0);
        check("ill_au_en", au_en, 0);
        check("ill_mode_kept", au_mode, last_mode);
        check("ill_map_kept", au_map, last_map);
        step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0);
        check("ill_err_clear", err, 0);
        check("ill_au_rst2", au_rst, 0);
        check("ill_ready2", cmd_ready, 1);
    endtask

    // One legal operation. The stall plan holds, for each global beat
    // index, how many stalled cycles precede that beat. drop_rd0 withholds
    // round 0's completion pulse. rst_beat >= 0 resets the block at that
    // beat.
    task automatic run_op(input logic [2:0] mode, input logic [1:0] map, input int stall_pct,
                          input bit directed, input bit drop_rd0, input int rst_beat);
        int   lens[$];
        int   plan[256];
        int   total;
        int   stall_total;
        int   gbeat;
        int   b;
        int   k;
        int   lat_exp;
        int   nr;
        bit   ntt;
        logic rd_p;
        logic dn_p;
        logic s;

        ntt = (mode == 3'd0) || (mode == 3'd1);
        nr  = ntt ? 4 : 1;
        lens.delete();
        for (int r = 0; r < nr; r++) lens.push_back(((mode == 3'd1) && (r == 0)) ? 63 : 64);
        total = 0;
        foreach (lens[i]) total += lens[i];

        for (int g = 0; g < 256; g++) begin
            if (directed) plan[g] = 0;
            else if ($urandom_range(0, 99) < stall_pct) plan[g] = $urandom_range(1, 3);
            else plan[g] = 0;
        end
        if (directed) begin
            plan[10] = 5;
            plan[40] = 1;
        end
        stall_total = 0;
        for (int g = 0; g < total; g++) stall_total += plan[g];

        lat_exp = 1 + ((mode == 3'd1) ? 255 : (ntt ? 256 : 64)) + (ntt ? 3 * RG : 0) + DR + stall_total;

        offer(mode, map);
        step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b1);
        k = 0;
        check("init_au_rst", au_rst, 1);
        check("init_au_en", au_en, 0);
        check("init_busy", busy, 1);
        check("init_ready", cmd_ready, 0);
        check("init_mode", au_mode, mode);
        check("init_map", au_map, map);
        last_mode = mode;
        last_map  = map;

        gbeat = 0;
        rd_p  = 1'b0;
        dn_p  = 1'b0;
        for (int r = 0; r < nr; r++) begin
            b = 0;
            while (b < lens[r]) begin
                if (gbeat == rst_beat) begin
                    step(1'b0, rd_p, dn_p, 1'b1, 1'b0);
                    check("rst_cycle_en", au_en, 1);
                    step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0);
                    check("rst_busy", busy, 0);
                    check("rst_au_en", au_en, 0);
                    check("rst_ready", cmd_ready, 1);
                    check("rst_op_done", op_done, 0);
                    check("rst_err", err, 0);
                    check("rst_mode", au_mode, 0);
                    check("rst_map", au_map, 2);
                    last_mode = 3'd0;
                    last_map  = 2'd2;
                    watch(300);
                    return;
                end
                s = (plan[gbeat] > 0);
                step(s, rd_p, dn_p, 1'b0, 1'b1);
                rd_p = 1'b0;
                dn_p = 1'b0;
                k++;
                check("run_au_en", au_en, !s);
                check("run_busy", busy, 1);
                check("run_err", err, 0);
                check("run_op_done", op_done, 0);
                check("run_au_rst", au_rst, 0);
                if (s) plan[gbeat]--;
                else begin
                    b++;
                    gbeat++;
                end
            end
            if (drop_rd0 && (r == 0)) begin
                step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                check("drop_chk_en", au_en, 0);
                check("drop_chk_err", err, 0);
                step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0);
                check("drop_err", err, 1);
                check("drop_busy", busy, 0);
                check("drop_ready", cmd_ready, 1);
                check("drop_au_en", au_en, 0);
                check("drop_op_done", op_done, 0);
                step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0);
                check("drop_err_clear", err, 0);
                watch(300);
                return;
            end
            // Address-unit model: pulse in the cycle after the round's last beat.
            rd_p = ntt;
            dn_p = (r == nr - 1);
            if (r != nr - 1) begin
                for (int i = 0; i < RG; i++) begin
                    step(1'($urandom_range(0, 1)), rd_p, dn_p, 1'b0, 1'b1);
                    rd_p = 1'b0;
                    dn_p = 1'b0;
                    k++;
                    check("gap_au_en", au_en, 0);
                    check("gap_busy", busy, 1);
                    check("gap_err", err, 0);
                end
            end
        end
        for (int i = 0; i < DR; i++) begin
            step(1'($urandom_range(0, 1)), rd_p, dn_p, 1'b0, 1'b1);
            rd_p = 1'b0;
            dn_p = 1'b0;
            k++;
            check("drain_au_en", au_en, 0);
            check("drain_busy", busy, 1);
            check("drain_err", err, 0);
            check("drain_op_done", op_done, 0);
            check("drain_ready", cmd_ready, 0);
        end
        step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0);
        k++;
        check("done_pulse", op_done, 1);
        check("done_latency", k, lat_exp);
        check("done_busy", busy, 1);
        check("done_ready", cmd_ready, 0);
        check("done_err", err, 0);
        check("done_au_en", au_en, 0);
        step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0);
        check("post_op_done", op_done, 0);
        check("post_busy", busy, 0);
        check("post_ready", cmd_ready, 1);
        check("post_err", err, 0);
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        rst           = 1'b1;
        cmd_valid     = 1'b0;
        cmd_mode      = 3'd0;
        cmd_map       = 2'd0;
        stall         = 1'b0;
        au_round_done = 1'b0;
        au_done       = 1'b0;
        last_mode     = 3'd0;
        last_map      = 2'd2;

        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("reset_ready", cmd_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_au_rst", au_rst, 0);
        check("reset_au_en", au_en, 0);
        check("reset_op_done", op_done, 0);
        check("reset_err", err, 0);
        check("reset_mode", au_mode, 0);
        check("reset_map", au_map, 2);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_idle_en", au_en, 0);

        run_op(3'd3, 2'd2, 0, 1'b0, 1'b0, -1);   // ADD
        run_op(3'd0, 2'd1, 0, 1'b0, 1'b0, -1);   // FWD_NTT
        run_op(3'd1, 2'd0, 0, 1'b0, 1'b0, -1);   // INV_NTT
        run_op(3'd2, 2'd2, 0, 1'b1, 1'b0, -1);   // MULT, stall before beats 10..14 and 40
        illegal(3'd6);
        run_op(3'd0, 2'd2, 0, 1'b0, 1'b1, -1);   // FWD_NTT, round 0 pulse withheld
        run_op(3'd0, 2'd3, 0, 1'b0, 1'b0, 100);  // FWD_NTT, reset at beat 100
        run_op(3'd4, 2'd2, 0, 1'b0, 1'b0, -1);   // SUB after reset

        for (int n = 0; n < 10; n++) begin
            if ($urandom_range(0, 5) == 0) illegal(3'($urandom_range(5, 7)));
            else run_op(3'($urandom_range(0, 4)), 2'($urandom_range(0, 3)),
                        $urandom_range(0, 20), 1'b0, 1'b0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
